// File: rtl/nf10_axis_downsizer.sv
// AXI4-Stream 256-to-64 width down-converter with tuser on the first beat and trailing-lane trimming.
// Optional macro NF10_AXIS_DOWNSIZER_STATS_EN adds packet/beat counters.
module nf10_axis_downsizer #(
  parameter int C_S_AXIS_DATA_WIDTH = 256,
  parameter int C_M_AXIS_DATA_WIDTH = 64,
  parameter int C_TUSER_WIDTH       = 128
) (
  input  logic                             axi_aclk,
  input  logic                             axi_reset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic [C_TUSER_WIDTH-1:0]         s_axis_tuser,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  input  logic                             s_axis_tlast,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic [C_TUSER_WIDTH-1:0]         m_axis_tuser,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic                             m_axis_tlast
`ifdef NF10_AXIS_DOWNSIZER_STATS_EN
  ,
  output logic [31:0]                      pkt_count,
  output logic [31:0]                      beat_count
`endif
);

  localparam int RATIO  = C_S_AXIS_DATA_WIDTH / C_M_AXIS_DATA_WIDTH;
  localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int STRB_M = C_M_AXIS_DATA_WIDTH / 8;

  localparam logic [0:0] ST_EMPTY     = 1'b0;
  localparam logic [0:0] ST_SERIALISE = 1'b1;

  logic [0:0]                       state;
  logic [C_S_AXIS_DATA_WIDTH-1:0]   held_data;
  logic [C_S_AXIS_DATA_WIDTH/8-1:0] held_strb;
  logic [C_TUSER_WIDTH-1:0]         held_user;
  logic                             held_last;
  logic                             held_first;
  logic                             first_pkt;
  logic [LANE_W-1:0]                lane;
  logic [LANE_W-1:0]                end_lane;
  logic [LANE_W-1:0]                load_end_lane;
  logic                             out_valid;
  logic                             final_lane;
  logic                             out_fire;
  logic                             accept;

  assign out_valid     = (state == ST_SERIALISE);
  assign final_lane    = (lane == end_lane);
  assign out_fire      = out_valid && m_axis_tready;
  assign s_axis_tready = !out_valid || (m_axis_tready && final_lane);
  assign accept        = s_axis_tvalid && s_axis_tready;

  // On a final beat, stop at the highest lane carrying any strobe; empty strobe still emits lane 0.
  always_comb begin
    load_end_lane = '1;
    if (s_axis_tlast) begin
      load_end_lane = '0;
      for (int k = 0; k < RATIO; k++) begin
        if (|s_axis_tstrb[k*STRB_M +: STRB_M]) load_end_lane = LANE_W'(k);
      end
    end
  end

  always_comb begin
    m_axis_tdata = '0;
    m_axis_tstrb = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (lane == LANE_W'(k)) begin
        m_axis_tdata = held_data[k*C_M_AXIS_DATA_WIDTH +: C_M_AXIS_DATA_WIDTH];
        m_axis_tstrb = held_strb[k*STRB_M +: STRB_M];
      end
    end
  end

  assign m_axis_tvalid = out_valid;
  assign m_axis_tlast  = held_last && final_lane;
  assign m_axis_tuser  = (lane == '0 && held_first) ? held_user : '0;

  // A final-lane handoff and a new load share one cycle, so reload takes priority over going empty.
  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      state      <= ST_EMPTY;
      held_data  <= '0;
      held_strb  <= '0;
      held_user  <= '0;
      held_last  <= 1'b0;
      held_first <= 1'b0;
      first_pkt  <= 1'b1;
      lane       <= '0;
      end_lane   <= '0;
    end else if (accept) begin
      state      <= ST_SERIALISE;
      held_data  <= s_axis_tdata;
      held_strb  <= s_axis_tstrb;
      held_user  <= s_axis_tuser;
      held_last  <= s_axis_tlast;
      held_first <= first_pkt;
      first_pkt  <= s_axis_tlast;
      lane       <= '0;
      end_lane   <= load_end_lane;
    end else if (out_fire) begin
      if (!final_lane) lane <= lane + LANE_W'(1);
      else             state <= ST_EMPTY;
    end
  end

`ifdef NF10_AXIS_DOWNSIZER_STATS_EN
  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      pkt_count  <= '0;
      beat_count <= '0;
    end else if (out_fire) begin
      beat_count <= beat_count + 32'd1;
      if (m_axis_tlast) pkt_count <= pkt_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_nf10_axis_downsizer.sv
// Directed self-checking bench for nf10_axis_downsizer; stats checks run when NF10_AXIS_DOWNSIZER_STATS_EN is defined.
`timescale 1ns/1ps
module tb_nf10_axis_downsizer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [255:0] s_data = '0;
  logic [31:0]  s_strb = '0;
  logic [127:0] s_user = '0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic         s_last = 1'b0;
  logic [63:0]  m_data;
  logic [7:0]   m_strb;
  logic [127:0] m_user;
  logic         m_valid;
  logic         m_ready = 1'b1;
  logic         m_last;
`ifdef NF10_AXIS_DOWNSIZER_STATS_EN
  logic [31:0]  pkt_count;
  logic [31:0]  beat_count;
`endif

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int last_acc = 0;
  int stall_viol = 0;
  bit toggle_mode = 0;

  typedef struct {
    logic [63:0]  data;
    logic [7:0]   strb;
    logic [127:0] user;
    logic         last;
    int           cyc;
  } beat_t;
  beat_t q[$];

  localparam logic [127:0] U1 = 128'h0000_0000_0000_0000_0000_0000_0040_0201;
  localparam logic [127:0] U2 = 128'h0000_0000_0000_0000_0000_0000_00C0_0102;
  localparam logic [127:0] U3 = 128'h0000_0000_0000_0000_0000_0000_0040_0804;
  localparam logic [127:0] U4 = 128'h0000_0000_0000_0000_0000_0000_00A0_0110;
  localparam logic [127:0] U6 = 128'h0000_0000_0000_0000_0000_0000_0040_4001;

  nf10_axis_downsizer dut (
    .axi_aclk      (clk),
    .axi_reset     (rst),
    .s_axis_tdata  (s_data),
    .s_axis_tstrb  (s_strb),
    .s_axis_tuser  (s_user),
    .s_axis_tvalid (s_valid),
    .s_axis_tready (s_ready),
    .s_axis_tlast  (s_last),
    .m_axis_tdata  (m_data),
    .m_axis_tstrb  (m_strb),
    .m_axis_tuser  (m_user),
    .m_axis_tvalid (m_valid),
    .m_axis_tready (m_ready),
    .m_axis_tlast  (m_last)
`ifdef NF10_AXIS_DOWNSIZER_STATS_EN
    ,
    .pkt_count     (pkt_count),
    .beat_count    (beat_count)
`endif
  );

  always #10 clk = ~clk;

  always @(negedge clk) m_ready = toggle_mode ? ~m_ready : 1'b1;

  // Records every output handshake and flags any change on a stalled output.
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data;
  logic [7:0]  prev_strb;
  logic        prev_last;
  always begin
    beat_t b;
    @(negedge clk);
    #3;
    cycle++;
    if (rst) prev_stall = 1'b0;
    else begin
      if (m_valid && m_ready) begin
        b.data = m_data; b.strb = m_strb; b.user = m_user; b.last = m_last; b.cyc = cycle;
        q.push_back(b);
      end
      if (prev_stall && (!m_valid || m_data !== prev_data || m_strb !== prev_strb || m_last !== prev_last))
        stall_viol++;
      prev_stall = m_valid && !m_ready;
      prev_data = m_data; prev_strb = m_strb; prev_last = m_last;
    end
  end

  function automatic logic [255:0] mk(input logic [63:0] base);
    return {base + 64'd3, base + 64'd2, base + 64'd1, base};
  endfunction

  // Called at a negedge; returns at the negedge after the beat is accepted.
  task automatic push(input logic [255:0] d, input logic [31:0] s, input logic [127:0] u, input logic l);
    s_data = d; s_strb = s; s_user = u; s_last = l; s_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      #2;
      if (s_ready) begin
        last_acc = cycle + 1;
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    checks++; errors++;
    $display("[TB] FAIL push_timeout: s_tready=%0b required 1", s_ready);
    s_valid = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      #4;
      if (q.size() >= n) break;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    #4;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b need 0", m_valid); end
    checks++; if (m_data !== 64'd0) begin errors++; $display("[TB] FAIL reset_data: got %h need 0", m_data); end
    checks++; if (m_user !== 128'd0 || m_strb !== 8'd0 || m_last !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_misc: user=%h strb=%h last=%0b need zeros", m_user, m_strb, m_last); end
    @(negedge clk);
    rst = 1'b0;
    #4;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_sready: got %0b need 1", s_ready); end
    @(negedge clk);
  endtask

  task automatic test_full_beat;
    int acc;
    q.delete();
    push(mk(64'h1000), 32'hFFFF_FFFF, U1, 1'b1);
    acc = last_acc;
    s_valid = 1'b0;
    wait_beats(4);
    checks++; if (q.size() != 4) begin errors++; $display("[TB] FAIL full_count: got %0d need 4", q.size()); end
    if (q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (q[i].data !== 64'h1000 + 64'(i) || q[i].strb !== 8'hFF || q[i].last !== (i == 3) ||
            q[i].user !== ((i == 0) ? U1 : 128'd0) || q[i].cyc != acc + 1 + i) begin
          errors++;
          $display("[TB] FAIL full_beat%0d: data=%h strb=%h last=%0b user=%h cyc=%0d need data=%h strb=ff last=%0b cyc=%0d",
                   i, q[i].data, q[i].strb, q[i].last, q[i].user, q[i].cyc, 64'h1000 + 64'(i), (i == 3), acc + 1 + i);
        end
      end
    end
  endtask

  task automatic test_partial_last;
    q.delete();
    push(mk(64'h7000), 32'h0000_0FFF, U1, 1'b1);
    s_valid = 1'b0;
    wait_beats(2);
    checks++; if (q.size() != 2) begin errors++; $display("[TB] FAIL partial_count: got %0d need 2", q.size()); end
    if (q.size() == 2) begin
      checks++;
      if (q[0].strb !== 8'hFF || q[0].last !== 1'b0 || q[0].data !== 64'h7000) begin
        errors++; $display("[TB] FAIL partial_b0: strb=%h last=%0b data=%h need ff 0 7000", q[0].strb, q[0].last, q[0].data); end
      checks++;
      if (q[1].strb !== 8'h0F || q[1].last !== 1'b1 || q[1].data !== 64'h7001) begin
        errors++; $display("[TB] FAIL partial_b1: strb=%h last=%0b data=%h need 0f 1 7001", q[1].strb, q[1].last, q[1].data); end
    end
  endtask

  task automatic test_back_to_back;
    int acc[4];
    logic [63:0] bases[4];
    bases[0] = 64'h2000; bases[1] = 64'h2010; bases[2] = 64'h2020; bases[3] = 64'h3000;
    q.delete();
    push(mk(bases[0]), 32'hFFFF_FFFF, U2, 1'b0);      acc[0] = last_acc;
    push(mk(bases[1]), 32'hFFFF_FFFF, 128'd0, 1'b0);  acc[1] = last_acc;
    push(mk(bases[2]), 32'hFFFF_FFFF, 128'd0, 1'b1);  acc[2] = last_acc;
    push(mk(bases[3]), 32'hFFFF_FFFF, U3, 1'b1);      acc[3] = last_acc;
    s_valid = 1'b0;
    wait_beats(16);
    for (int k = 1; k < 4; k++) begin
      checks++;
      if (acc[k] - acc[k-1] != 4) begin
        errors++; $display("[TB] FAIL b2b_accept_gap%0d: got %0d need 4", k, acc[k] - acc[k-1]); end
    end
    checks++; if (q.size() != 16) begin errors++; $display("[TB] FAIL b2b_count: got %0d need 16", q.size()); end
    if (q.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (q[i].data !== bases[i/4] + 64'(i % 4) || q[i].cyc != q[0].cyc + i ||
            q[i].last !== (i == 11 || i == 15) ||
            q[i].user !== ((i == 0) ? U2 : (i == 12) ? U3 : 128'd0)) begin
          errors++;
          $display("[TB] FAIL b2b_beat%0d: data=%h cyc=%0d last=%0b user=%h need data=%h cyc=%0d",
                   i, q[i].data, q[i].cyc, q[i].last, q[i].user, bases[i/4] + 64'(i % 4), q[0].cyc + i);
        end
      end
    end
  endtask

  task automatic test_stall;
    logic [63:0] exp_data[7];
    for (int i = 0; i < 4; i++) exp_data[i] = 64'h4000 + 64'(i);
    for (int i = 0; i < 3; i++) exp_data[4+i] = 64'h4010 + 64'(i);
    q.delete();
    stall_viol = 0;
    toggle_mode = 1'b1;
    push(mk(64'h4000), 32'hFFFF_FFFF, U4, 1'b0);
    push(mk(64'h4010), 32'h00FF_FFFF, 128'd0, 1'b1);
    s_valid = 1'b0;
    wait_beats(7);
    toggle_mode = 1'b0;
    checks++; if (stall_viol != 0) begin errors++; $display("[TB] FAIL stall_hold: got %0d changes need 0", stall_viol); end
    checks++; if (q.size() != 7) begin errors++; $display("[TB] FAIL stall_count: got %0d need 7", q.size()); end
    if (q.size() == 7) begin
      for (int i = 0; i < 7; i++) begin
        checks++;
        if (q[i].data !== exp_data[i] || q[i].last !== (i == 6) || q[i].strb !== 8'hFF) begin
          errors++; $display("[TB] FAIL stall_beat%0d: data=%h last=%0b strb=%h need %h %0b ff",
                             i, q[i].data, q[i].last, q[i].strb, exp_data[i], (i == 6)); end
      end
    end
  endtask

  task automatic test_reset_mid;
    q.delete();
    push(mk(64'h5000), 32'hFFFF_FFFF, U1, 1'b0);
    s_valid = 1'b0;
    wait_beats(3);
    // wait_beats idles 3 cycles, so re-push to land reset during lane 2
    q.delete();
    rst = 1'b1; #2; rst = 1'b0;
    @(negedge clk);
    push(mk(64'h5000), 32'hFFFF_FFFF, U1, 1'b0);
    s_valid = 1'b0;
    for (int i = 0; i < 20 && q.size() < 3; i++) begin @(negedge clk); #4; end
    #1 rst = 1'b1;
    #1;
    checks++; if (m_valid !== 1'b0 || m_data !== 64'd0) begin
      errors++; $display("[TB] FAIL midreset_out: valid=%0b data=%h need 0 0", m_valid, m_data); end
    checks++; if (m_last !== 1'b0 || m_user !== 128'd0) begin
      errors++; $display("[TB] FAIL midreset_misc: last=%0b user=%h need 0 0", m_last, m_user); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    q.delete();
    push(mk(64'h6000), 32'hFFFF_FFFF, U6, 1'b1);
    s_valid = 1'b0;
    wait_beats(4);
    checks++; if (q.size() != 4) begin errors++; $display("[TB] FAIL midreset_count: got %0d need 4", q.size()); end
    if (q.size() == 4) begin
      checks++;
      if (q[0].user !== U6 || q[0].data !== 64'h6000) begin
        errors++; $display("[TB] FAIL midreset_first: user=%h data=%h need %h 6000", q[0].user, q[0].data, U6); end
      checks++;
      if (q[3].last !== 1'b1 || q[3].data !== 64'h6003) begin
        errors++; $display("[TB] FAIL midreset_last: last=%0b data=%h need 1 6003", q[3].last, q[3].data); end
    end
  endtask

`ifdef NF10_AXIS_DOWNSIZER_STATS_EN
  task automatic test_stats;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int p = 1; p <= 5; p++) begin
      for (int b = 0; b < p; b++) push(mk(64'h8000), 32'hFFFF_FFFF, U1, (b == p - 1));
    end
    s_valid = 1'b0;
    repeat (8) @(negedge clk);
    checks++; if (pkt_count !== 32'd5) begin errors++; $display("[TB] FAIL stats_pkt: got %0d need 5", pkt_count); end
    checks++; if (beat_count !== 32'd60) begin errors++; $display("[TB] FAIL stats_beat: got %0d need 60", beat_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_full_beat();
    test_partial_last();
    test_back_to_back();
    test_stall();
    test_reset_mid();
`ifdef NF10_AXIS_DOWNSIZER_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nf10_axis_downsizer.md
Name: nf10_axis_downsizer

Overview:
- AXI4-Stream width down-converter: accepts 256-bit packet beats and serialises each into up to four 64-bit beats, low lane first.
- Return-path counterpart to the 64-to-256 upsizer: sits between the 256-bit datapath core and the 64-bit 10G MAC-side ports.
- Carries the NetFPGA 128-bit tuser metadata (len/spt/dpt) on the first output beat of each packet.
- Trims empty trailing lanes on the final beat of a packet.

Parameters:
- C_S_AXIS_DATA_WIDTH, 256, slave data width; must be an integer power-of-2 multiple of the master width.
- C_M_AXIS_DATA_WIDTH, 64, master data width.
- C_TUSER_WIDTH, 128, tuser width on both sides.
- Derived RATIO = C_S/C_M (4). Lane-index width = log2(RATIO).

Ports:
- axi_aclk  in  1  clock, all logic rising-edge.
- axi_reset  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  256  input data; lane k = bits[64k+63:64k].
- s_axis_tstrb  in  32  byte strobes, contiguous from LSB.
- s_axis_tuser  in  128  metadata, valid on first beat of packet.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  end of packet.
- m_axis_tdata  out  64  output data.
- m_axis_tstrb  out  8  output strobes.
- m_axis_tuser  out  128  metadata.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  end of packet.

Behaviour:
- Reset values (asynchronous): m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata/tstrb/tuser=0, holding register empty, lane counter=0, first-of-packet flag=1.
- Storage: one 256-bit holding register with its strobe, tuser, last flag and valid bit. States: EMPTY (valid=0) and SERIALISE (valid=1).
- s_axis_tready = !valid || (m_axis_tready && lane==end_lane). This gives back-to-back reload with no bubble.
- Accept (s_tvalid && s_tready):
  - Load the holding register and set lane=0.
  - end_lane = RATIO-1 when tlast=0.
  - When tlast=1, end_lane = index of the highest lane with any strobe bit set; all-zero strobe gives end_lane=0.
- Latency: the first output beat is valid the cycle after the input is accepted (registered outputs). Throughput: end_lane+1 cycles per input beat when m_tready stays high.
- Output beat:
  - m_tdata/m_tstrb = lane `lane` of the holding register.
  - m_tlast = held_last && (lane==end_lane).
  - m_tuser = held tuser when lane==0 and first-of-packet=1, otherwise 0.
- Advance on m_tvalid && m_tready:
  - If lane<end_lane: lane++.
  - Otherwise: reload if input accepted in the same cycle, else go to EMPTY.
- m_axis_tvalid and m_axis_tdata are stable while m_tvalid && !m_tready (AXI rule).
- First-of-packet flag: cleared when a beat is accepted with tlast=0; set when a beat is accepted with tlast=1.
- tstrb checks: non-contiguous strobes are not checked. Lanes above end_lane on the last beat are discarded.
- Reset mid-packet: the partial packet is dropped. The first beat after reset is treated as a packet start.
- Simultaneous final-lane handoff and new input: both happen in one cycle; the new word's lane 0 appears the next cycle.

Optional Feature:
- Macro: NF10_AXIS_DOWNSIZER_STATS_EN.
- When defined:
  - Adds output ports pkt_count[31:0] and beat_count[31:0].
  - pkt_count increments on each m_tlast handshake.
  - beat_count increments on each m_tvalid&&m_tready.
  - Both reset to 0 and wrap at 2^32.
- When undefined: the ports and counters are absent; datapath behaviour is identical.

Test Plan:
- Single beat, tstrb=32'hFFFFFFFF, tlast=1, tuser=128'h…0040_0201, m_tready=1 -> 4 beats on cycles 1-4 with lanes 0..3, strobes FF each, tlast only on beat 4, tuser only on beat 1.
- Last beat tstrb=32'h0000_0FFF -> 2 output beats, tstrb FF then 0F, tlast on beat 2.
- 3-beat packet then immediate 1-beat packet, m_tready=1 -> 12+4 contiguous output beats with no idle cycle; s_tready low except on each final-lane cycle.
- m_tready toggled 1/0 every cycle -> data/tstrb/tlast held while stalled; no duplicated or lost lanes; beat order exact.
- axi_reset asserted during lane 2 of a multi-beat packet -> outputs zero asynchronously. The next packet's first beat carries its tuser.
- With STATS_EN: 5 packets of 1,2,3,4,5 full input beats -> pkt_count=5, beat_count=60.
